fsm_lect_ram: RTL and testbench
===============================

Name: fsm_lect_ram

Overview:
- Read-side counterpart of the ROM-to-RAM initialisation FSM.
- On a start pulse it sweeps a contiguous window of the shared RAM through its synchronous read port.
- It streams the words out with valid/ready backpressure to a downstream consumer, such as the display/RTC formatting path.
- It owns the RAM read enable; it never drives the write enable.

Parameters:
- ADDR_W, 32, width of dir_ram (matches the RAM address bus).
- DATA_W, 8, RAM word width.
- LEN_W, 17, width of the word-count input (matches the ROM address width used for initialisation).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- do_it_lect_ram  in  1  start request, sampled on a rising edge; 1-cycle pulse expected.
- base_dir  in  ADDR_W  first RAM address; latched at start.
- num_words  in  LEN_W  number of words to read; latched at start.
- dir_ram  out  ADDR_W  RAM read address.
- r_ram_enable  out  1  RAM read enable; 1-cycle read latency assumed by design.
- ram_data  in  DATA_W  RAM read data, valid in the cycle after r_ram_enable.
- data_out  out  DATA_W  head-of-buffer word.
- data_valid  out  1  data_out holds a valid word.
- data_ready  in  1  consumer accepts; transfer when data_valid && data_ready.
- busy  out  1  sweep in progress.
- done  out  1  1-cycle pulse after the last word transfers.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; dir_ram=0; r_ram_enable=0; data_out=0; data_valid=0; busy=0; done=0.
  - Buffer is emptied; in-flight flag and counters are cleared.
- States:
  - IDLE: on do_it_lect_ram=1, latch base_dir and num_words, busy<=1. If num_words=0, go to FIN; else go to READ.
  - READ: issue reads until remaining issues = 0, then go to DRAIN.
  - DRAIN: wait until the buffer is empty, no read is in flight and all num_words are transferred, then go to FIN.
  - FIN: done=1 and busy=1 for exactly one cycle, then go to IDLE with busy<=0.
- Read issue rule: r_ram_enable=1 in a cycle iff state=READ, remaining>0 and (count + inflight − pop) < 2.
  - count = buffer occupancy (0..2); inflight = read issued in the previous cycle; pop = current transfer.
  - Each issue: dir_ram advances by 1 (modulo 2^ADDR_W); remaining decrements.
  - dir_ram holds its last value when not reading.
- Buffer: 2-entry FIFO captures ram_data on the cycle after each issue. Capacity is never exceeded because of the issue rule.
- Latency: start sampled at edge N.
  - r_ram_enable=1 with dir_ram=base_dir in cycle N+1.
  - data_valid=1 in cycle N+3.
- Throughput: 1 word/cycle while data_ready is held high.
- Backpressure: with data_ready=0, data_valid and data_out hold stable; at most 2 reads are outstanding.
- Word order equals address order; no word is dropped or duplicated.
- do_it_lect_ram while busy=1 is ignored; base_dir and num_words changes after start are ignored.
- Simultaneous capture and pop in the same cycle is legal; count is unchanged.
- Address wrap: base_dir + num_words exceeding 2^ADDR_W wraps to 0 silently.
- Reset mid-sweep aborts immediately to the reset values; no done pulse is produced.
- w_ram_enable is not an output of this block; the integrator ties the write path to the initialisation FSM.

Optional Feature:
- Macro: LECT_RAM_WRAP_EN.
- Defined:
  - Adds input stop_lect (1 bit).
  - After the last address is issued, dir_ram reloads base_dir and remaining reloads num_words; reading continues indefinitely (refresh loop).
  - stop_lect=1 stops new issues; the block drains and pulses done.
  - With num_words=0, done is still immediate.
- Not defined: one-shot sweep as above; no stop_lect port.

Decomposition:
- Shared package lect_ram_pkg:
  - state encoding constants ST_IDLE, ST_READ, ST_DRAIN, ST_FIN (2-bit).
  - default widths ADDR_W=32, DATA_W=8, LEN_W=17.
- One natural sub-module: lect_ram_skid_buf, the 2-entry FIFO with count, push/pop and data_out/data_valid.
- The FSM, address counter and issue logic stay in fsm_lect_ram.

Test Plan:
- RAM model preloaded mem[i]=i[7:0]; base_dir=0x10, num_words=4, data_ready=1 -> r_ram_enable in cycles N+1..N+4 at addresses 0x10..0x13; data_out 0x10,0x11,0x12,0x13 in cycles N+3..N+6; done pulse in N+7; busy low in N+8.
- Same as above, but data_ready toggles 1,0,0,1,... -> identical word sequence with no loss; r_ram_enable never leaves more than 2 words outstanding; data_out stable while data_ready=0.
- num_words=0 -> no r_ram_enable; done pulse in N+1; busy high only in N+1.
- base_dir=0xFFFF_FFFE, num_words=4 -> addresses FFFF_FFFE, FFFF_FFFF, 0, 1.
- Second do_it_lect_ram pulse mid-sweep -> ignored, single done. reset=0 mid-sweep -> all outputs 0 immediately, no done; a restart afterwards works from the new base_dir.
- With LECT_RAM_WRAP_EN, base_dir=0, num_words=3 -> addresses 0,1,2,0,1,2,...; assert stop_lect -> in-flight words drain, then one done pulse.

Source files
------------

// File: rtl/lect_ram_pkg.sv
// -----------------------------------------------------------------------------
// lect_ram_pkg
// Shared definitions for the RAM read-sweep block (fsm_lect_ram) and its
// output skid buffer (lect_ram_skid_buf).
//   - state_e : 2-bit FSM encoding ST_IDLE / ST_READ / ST_DRAIN / ST_FIN
//   - DEF_*   : default widths of the RAM address bus, RAM word and word count
// -----------------------------------------------------------------------------
package lect_ram_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage : lect_ram_pkg

// File: rtl/lect_ram_skid_buf.sv
// -----------------------------------------------------------------------------
// lect_ram_skid_buf
// Two-entry FIFO that captures RAM read data one cycle after each read issue
// and presents the head word to the consumer with valid/ready handshaking.
// Ports:
//   clk          in   system clock (rising edge)
//   reset        in   asynchronous active-low reset (empties buffer, zeroes data)
//   push_i       in   capture push_data_i this cycle
//   push_data_i  in   word to capture (RAM read data)
//   pop_i        in   head word accepted by the consumer this cycle
//   data_o       out  head-of-buffer word
//   valid_o      out  buffer holds at least one word
//   count_o      out  occupancy, 0..2
// The producer guarantees push never hits a full buffer without a pop.
// -----------------------------------------------------------------------------
module lect_ram_skid_buf
  import lect_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              pop_ok;

  // A pop on an empty buffer is meaningless; ignore it rather than underflow.
  assign pop_ok = pop_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule : lect_ram_skid_buf

// File: rtl/fsm_lect_ram.sv
// -----------------------------------------------------------------------------
// fsm_lect_ram
// Read-side counterpart of the ROM-to-RAM initialisation FSM. A start pulse
// sweeps num_words consecutive RAM addresses from base_dir through the RAM's
// synchronous read port (1-cycle latency) and streams the words out with
// valid/ready backpressure. The block never drives the RAM write enable.
// Ports:
//   clk             in   system clock (rising edge)
//   reset           in   asynchronous active-low reset
//   do_it_lect_ram  in   start pulse, ignored while busy
//   base_dir        in   first RAM address (latched at start)
//   num_words       in   number of words to read (latched at start)
//   dir_ram         out  RAM read address
//   r_ram_enable    out  RAM read enable
//   ram_data        in   RAM read data, valid the cycle after r_ram_enable
//   data_out        out  head word towards the consumer
//   data_valid      out  data_out holds a valid word
//   data_ready      in   consumer accepts data_out
//   stop_lect       in   (LECT_RAM_WRAP_EN only) end the refresh loop
//   busy            out  sweep in progress
//   done            out  1-cycle pulse after the last word transfers
// Build option LECT_RAM_WRAP_EN: the sweep restarts at base_dir after the last
// address and keeps refreshing until stop_lect, then drains and pulses done.
// -----------------------------------------------------------------------------
module fsm_lect_ram
  import lect_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              do_it_lect_ram,
  input  logic [ADDR_W-1:0] base_dir,
  input  logic [LEN_W-1:0]  num_words,
  output logic [ADDR_W-1:0] dir_ram,
  output logic              r_ram_enable,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
`ifdef LECT_RAM_WRAP_EN
  input  logic              stop_lect,
`endif
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q,  inflight_d;
`ifdef LECT_RAM_WRAP_EN
  logic [ADDR_W-1:0] base_q,      base_d;
  logic [LEN_W-1:0]  num_q,       num_d;
  logic              stop_req;
`endif

  logic       pop;
  logic [1:0] buf_count;
  logic       room_ok;
  logic       issue;
  logic       last_pop_done;

  assign pop = data_valid && data_ready;

  // Buffer slots already committed (held + arriving) minus the one leaving
  // this cycle must leave a free slot, so a new read can never overflow.
  assign room_ok = ({1'b0, buf_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

`ifdef LECT_RAM_WRAP_EN
  assign stop_req = stop_lect;
  assign issue    = (state_q == ST_READ) && (remaining_q != '0) && room_ok && !stop_req;
`else
  assign issue    = (state_q == ST_READ) && (remaining_q != '0) && room_ok;
`endif

  // Drain ends in the cycle the final word leaves, so done follows immediately.
  assign last_pop_done = !inflight_q &&
                         ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    inflight_d  = issue;
`ifdef LECT_RAM_WRAP_EN
    base_d      = base_q;
    num_d       = num_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (do_it_lect_ram) begin
          addr_d      = base_dir;
          remaining_d = num_words;
`ifdef LECT_RAM_WRAP_EN
          base_d      = base_dir;
          num_d       = num_words;
`endif
          state_d     = (num_words == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ: begin
`ifdef LECT_RAM_WRAP_EN
        if (stop_req) begin
          state_d = ST_DRAIN;
        end else if (issue) begin
          if (remaining_q == LEN_ONE) begin
            addr_d      = base_q;
            remaining_d = num_q;
          end else begin
            addr_d      = addr_q + ADDR_ONE;
            remaining_d = remaining_q - LEN_ONE;
          end
        end
`else
        if (issue) begin
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = ST_DRAIN;
          end
        end else if (remaining_q == '0) begin
          state_d = ST_DRAIN;
        end
`endif
      end
      ST_DRAIN: begin
        if (last_pop_done) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
`ifdef LECT_RAM_WRAP_EN
      base_q      <= '0;
      num_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
`ifdef LECT_RAM_WRAP_EN
      base_q      <= base_d;
      num_q       <= num_d;
`endif
    end
  end

  // RAM data returns one cycle after the issue; capture it then.
  lect_ram_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (ram_data),
    .pop_i       (pop),
    .data_o      (data_out),
    .valid_o     (data_valid),
    .count_o     (buf_count)
  );

  assign dir_ram      = addr_q;
  assign r_ram_enable = issue;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN);

endmodule : fsm_lect_ram

// File: tb/tb_fsm_lect_ram.sv
// -----------------------------------------------------------------------------
// tb_fsm_lect_ram
// Directed bench for fsm_lect_ram with a RAM model holding mem[i] = i[7:0]
// (synchronous read, 1-cycle latency). Inputs change on the falling edge;
// outputs are sampled 1 time unit later. Cycle c=1 is the cycle right after
// the rising edge that samples the start pulse.
// -----------------------------------------------------------------------------
module tb_fsm_lect_ram;

  logic        clk;
  logic        reset;
  logic        do_it_lect_ram;
  logic [31:0] base_dir;
  logic [16:0] num_words;
  logic [31:0] dir_ram;
  logic        r_ram_enable;
  logic [7:0]  ram_data;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;
`ifdef LECT_RAM_WRAP_EN
  logic        stop_lect;
`endif

  int vectors;
  int miscompares;

  fsm_lect_ram dut (
    .clk            (clk),
    .reset          (reset),
    .do_it_lect_ram (do_it_lect_ram),
    .base_dir       (base_dir),
    .num_words      (num_words),
    .dir_ram        (dir_ram),
    .r_ram_enable   (r_ram_enable),
    .ram_data       (ram_data),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
`ifdef LECT_RAM_WRAP_EN
    .stop_lect      (stop_lect),
`endif
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: mem[i] = i[7:0], registered read.
  always @(posedge clk) begin
    if (r_ram_enable) ram_data <= dir_ram[7:0];
  end

  task automatic start_sweep(input logic [31:0] b, input logic [16:0] n);
    @(negedge clk);
    base_dir       = b;
    num_words      = n;
    do_it_lect_ram = 1'b1;
    @(negedge clk);
    do_it_lect_ram = 1'b0;
    // Changing the inputs after the start must have no effect.
    base_dir       = 32'hDEAD_BEEF;
    num_words      = 17'd9;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (dir_ram !== 32'h0) begin miscompares++; $display("FAIL reset_dir_ram got %h want 0", dir_ram); end
    vectors++; if (r_ram_enable !== 1'b0) begin miscompares++; $display("FAIL reset_r_ram_enable got %b want 0", r_ram_enable); end
    vectors++; if (data_out !== 8'h0) begin miscompares++; $display("FAIL reset_data_out got %h want 0", data_out); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    #9 reset = 1'b1;
  endtask

  task automatic test_basic();
    data_ready = 1'b1;
    start_sweep(32'h10, 17'd4);
    for (int c = 1; c <= 8; c++) begin
      #1;
      vectors++; if (r_ram_enable !== 1'((c >= 1) && (c <= 4))) begin miscompares++; $display("FAIL basic_en c=%0d got %b", c, r_ram_enable); end
      if (c <= 4) begin
        vectors++; if (dir_ram !== 32'(32'h10 + c - 1)) begin miscompares++; $display("FAIL basic_addr c=%0d got %h want %h", c, dir_ram, 32'(32'h10 + c - 1)); end
      end
      vectors++; if (data_valid !== 1'((c >= 3) && (c <= 6))) begin miscompares++; $display("FAIL basic_valid c=%0d got %b", c, data_valid); end
      if ((c >= 3) && (c <= 6)) begin
        vectors++; if (data_out !== 8'(8'h10 + c - 3)) begin miscompares++; $display("FAIL basic_data c=%0d got %h want %h", c, data_out, 8'(8'h10 + c - 3)); end
      end
      vectors++; if (done !== 1'(c == 7)) begin miscompares++; $display("FAIL basic_done c=%0d got %b", c, done); end
      vectors++; if (busy !== 1'(c <= 7)) begin miscompares++; $display("FAIL basic_busy c=%0d got %b", c, busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int issued, xfer, dones;
    logic prev_hold;
    logic [7:0] prev_data;
    pat = 4'b1001;  // index 0..3 -> ready 1,0,0,1
    issued = 0; xfer = 0; dones = 0; prev_hold = 1'b0; prev_data = 8'h0;
    data_ready = 1'b1;
    start_sweep(32'h10, 17'd4);
    for (int c = 1; c <= 24; c++) begin
      data_ready = pat[(c - 1) % 4];
      #1;
      if (prev_hold) begin
        vectors++; if (data_valid !== 1'b1 || data_out !== prev_data) begin miscompares++; $display("FAIL bp_hold c=%0d got %b/%h want 1/%h", c, data_valid, data_out, prev_data); end
      end
      if (r_ram_enable) begin
        vectors++; if (dir_ram !== 32'(32'h10 + issued)) begin miscompares++; $display("FAIL bp_addr c=%0d got %h want %h", c, dir_ram, 32'(32'h10 + issued)); end
        issued++;
      end
      if (data_valid && data_ready) begin
        vectors++; if (data_out !== 8'(8'h10 + xfer)) begin miscompares++; $display("FAIL bp_data c=%0d got %h want %h", c, data_out, 8'(8'h10 + xfer)); end
        xfer++;
      end
      vectors++; if (issued - xfer > 2) begin miscompares++; $display("FAIL bp_outstanding c=%0d got %0d want <=2", c, issued - xfer); end
      if (done) dones++;
      prev_hold = data_valid && !data_ready;
      prev_data = data_out;
      @(negedge clk);
    end
    data_ready = 1'b1;
    vectors++; if (issued != 4) begin miscompares++; $display("FAIL bp_issued got %0d want 4", issued); end
    vectors++; if (xfer != 4) begin miscompares++; $display("FAIL bp_words got %0d want 4", xfer); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL bp_dones got %0d want 1", dones); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_busy_end got %b want 0", busy); end
  endtask

  task automatic test_zero_words();
    data_ready = 1'b1;
    start_sweep(32'h20, 17'd0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      vectors++; if (r_ram_enable !== 1'b0) begin miscompares++; $display("FAIL zero_en c=%0d got %b want 0", c, r_ram_enable); end
      vectors++; if (done !== 1'(c == 1)) begin miscompares++; $display("FAIL zero_done c=%0d got %b", c, done); end
      vectors++; if (busy !== 1'(c == 1)) begin miscompares++; $display("FAIL zero_busy c=%0d got %b", c, busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_addr_wrap();
    data_ready = 1'b1;
    start_sweep(32'hFFFF_FFFE, 17'd4);
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (c <= 4) begin
        vectors++; if (r_ram_enable !== 1'b1 || dir_ram !== 32'(32'hFFFF_FFFE + c - 1)) begin miscompares++; $display("FAIL wrap_addr c=%0d got %b/%h want 1/%h", c, r_ram_enable, dir_ram, 32'(32'hFFFF_FFFE + c - 1)); end
      end
      if ((c >= 3) && (c <= 6)) begin
        vectors++; if (data_valid !== 1'b1 || data_out !== 8'(8'hFE + c - 3)) begin miscompares++; $display("FAIL wrap_data c=%0d got %b/%h want 1/%h", c, data_valid, data_out, 8'(8'hFE + c - 3)); end
      end
      vectors++; if (done !== 1'(c == 7)) begin miscompares++; $display("FAIL wrap_done c=%0d got %b", c, done); end
      @(negedge clk);
    end
  endtask

  task automatic test_restart_ignored();
    int issued, xfer, dones;
    issued = 0; xfer = 0; dones = 0;
    data_ready = 1'b1;
    start_sweep(32'h40, 17'd4);
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) begin
        do_it_lect_ram = 1'b1; base_dir = 32'h80; num_words = 17'd2;
      end else begin
        do_it_lect_ram = 1'b0;
      end
      #1;
      if (r_ram_enable) begin
        vectors++; if (dir_ram !== 32'(32'h40 + issued)) begin miscompares++; $display("FAIL restart_addr c=%0d got %h want %h", c, dir_ram, 32'(32'h40 + issued)); end
        issued++;
      end
      if (data_valid && data_ready) begin
        vectors++; if (data_out !== 8'(8'h40 + xfer)) begin miscompares++; $display("FAIL restart_data c=%0d got %h want %h", c, data_out, 8'(8'h40 + xfer)); end
        xfer++;
      end
      if (done) dones++;
      @(negedge clk);
    end
    vectors++; if (issued != 4 || xfer != 4) begin miscompares++; $display("FAIL restart_count got %0d/%0d want 4/4", issued, xfer); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL restart_dones got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b1;
    start_sweep(32'h50, 17'd4);
    #1; @(negedge clk);
    #1; @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++; if (dir_ram !== 32'h0 || r_ram_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_addr_en got %h/%b want 0/0", dir_ram, r_ram_enable); end
    vectors++; if (data_out !== 8'h0 || data_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_data got %h/%b want 0/0", data_out, data_valid); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_done got %b/%b want 0/0", busy, done); end
    @(negedge clk);
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      vectors++; if (done !== 1'b0 || busy !== 1'b0 || r_ram_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got done=%b busy=%b en=%b want 0", done, busy, r_ram_enable); end
    end
    start_sweep(32'h60, 17'd2);
    for (int c = 1; c <= 6; c++) begin
      #1;
      vectors++; if (r_ram_enable !== 1'(c <= 2)) begin miscompares++; $display("FAIL rstmid_re_en c=%0d got %b", c, r_ram_enable); end
      if (c <= 2) begin
        vectors++; if (dir_ram !== 32'(32'h60 + c - 1)) begin miscompares++; $display("FAIL rstmid_re_addr c=%0d got %h want %h", c, dir_ram, 32'(32'h60 + c - 1)); end
      end
      if ((c == 3) || (c == 4)) begin
        vectors++; if (data_valid !== 1'b1 || data_out !== 8'(8'h60 + c - 3)) begin miscompares++; $display("FAIL rstmid_re_data c=%0d got %b/%h want 1/%h", c, data_valid, data_out, 8'(8'h60 + c - 3)); end
      end
      vectors++; if (done !== 1'(c == 5)) begin miscompares++; $display("FAIL rstmid_re_done c=%0d got %b", c, done); end
      vectors++; if (busy !== 1'(c <= 5)) begin miscompares++; $display("FAIL rstmid_re_busy c=%0d got %b", c, busy); end
      @(negedge clk);
    end
  endtask

`ifdef LECT_RAM_WRAP_EN
  task automatic test_wrap_loop();
    int issued, xfer, dones;
    issued = 0; xfer = 0; dones = 0;
    data_ready = 1'b1;
    stop_lect  = 1'b0;
    start_sweep(32'h0, 17'd3);
    for (int c = 1; c <= 20; c++) begin
      if (c == 13) stop_lect = 1'b1;
      #1;
      if (c <= 12) begin
        vectors++; if (r_ram_enable !== 1'b1) begin miscompares++; $display("FAIL loop_en c=%0d got %b want 1", c, r_ram_enable); end
      end else begin
        vectors++; if (r_ram_enable !== 1'b0) begin miscompares++; $display("FAIL loop_stop_en c=%0d got %b want 0", c, r_ram_enable); end
      end
      if (r_ram_enable) begin
        vectors++; if (dir_ram !== 32'(issued % 3)) begin miscompares++; $display("FAIL loop_addr c=%0d got %h want %h", c, dir_ram, 32'(issued % 3)); end
        issued++;
      end
      if (data_valid && data_ready) begin
        vectors++; if (data_out !== 8'(xfer % 3)) begin miscompares++; $display("FAIL loop_data c=%0d got %h want %h", c, data_out, 8'(xfer % 3)); end
        xfer++;
      end
      if (done) dones++;
      @(negedge clk);
    end
    stop_lect = 1'b0;
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL loop_dones got %0d want 1", dones); end
    vectors++; if (issued != 12 || xfer != 12) begin miscompares++; $display("FAIL loop_count got %0d/%0d want 12/12", issued, xfer); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL loop_busy_end got %b want 0", busy); end
  endtask
`endif

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    do_it_lect_ram = 1'b0;
    base_dir       = 32'h0;
    num_words      = 17'd0;
    data_ready     = 1'b0;
    ram_data       = 8'h0;
`ifdef LECT_RAM_WRAP_EN
    stop_lect      = 1'b0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_words();
    test_addr_wrap();
    test_restart_ignored();
    test_reset_mid();
`ifdef LECT_RAM_WRAP_EN
    test_wrap_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fsm_lect_ram
